// File: rtl/match_sequencer.sv
// Pong match controller: sequences idle/serve/rally/point/over on the 1 ms tick,
// keeps both scores, picks the serve direction and gates the ball datapath.
module match_sequencer #(
  parameter int WIN_SCORE = 7,
  parameter int SERVE_MS  = 500,
  parameter int PAUSE_MS  = 1000,
  parameter int TIMER_W   = 10
) (
  input  logic       clk_1ms,
  input  logic       reset,
  input  logic       B,
  input  logic       miss_1,
  input  logic       miss_2,
  output logic [2:0] score_1,
  output logic [2:0] score_2,
  output logic       ball_en,
  output logic       ball_center,
  output logic       serve_dir,
  output logic [2:0] state,
  output logic [1:0] winner
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SERVE = 3'd1;
  localparam logic [2:0] RALLY = 3'd2;
  localparam logic [2:0] POINT = 3'd3;
  localparam logic [2:0] OVER  = 3'd4;

  localparam logic [2:0]         WIN        = 3'(WIN_SCORE);
  localparam logic [TIMER_W-1:0] SERVE_LAST = TIMER_W'(SERVE_MS - 1);
  localparam logic [TIMER_W-1:0] PAUSE_LAST = TIMER_W'(PAUSE_MS - 1);

  logic [2:0]         state_q, state_d;
  logic [2:0]         score1_q, score1_d;
  logic [2:0]         score2_q, score2_d;
  logic               dir_q, dir_d;
  logic [1:0]         winner_q, winner_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               b_q;
  logic               armed_q;

  logic               b_rise;
  logic [TIMER_W-1:0] timer_inc;
  logic [2:0]         score1_inc;
  logic [2:0]         score2_inc;

  // armed_q blocks a press that was already held when reset released;
  // B must be seen low once before any rise counts.
  assign b_rise     = B & ~b_q & armed_q;
  assign timer_inc  = (timer_q == {TIMER_W{1'b1}}) ? timer_q : timer_q + TIMER_W'(1);
  assign score1_inc = score1_q + 3'd1;
  assign score2_inc = score2_q + 3'd1;

  always_comb begin
    state_d  = state_q;
    score1_d = score1_q;
    score2_d = score2_q;
    dir_d    = dir_q;
    winner_d = winner_q;
    timer_d  = timer_q;
    case (state_q)
      IDLE: begin
        if (b_rise) begin
          state_d  = SERVE;
          timer_d  = '0;
          score1_d = 3'd0;
          score2_d = 3'd0;
          winner_d = 2'b00;
        end
      end
      SERVE: begin
        if (timer_q == SERVE_LAST) begin
          state_d = RALLY;
          timer_d = '0;
        end else begin
          timer_d = timer_inc;
        end
      end
      RALLY: begin
        if (miss_1 && !miss_2) begin
          score2_d = score2_inc;
          dir_d    = 1'b0;
          timer_d  = '0;
          if (score2_inc == WIN) begin
            state_d  = OVER;
            winner_d = 2'b10;
          end else begin
            state_d = POINT;
          end
        end else if (miss_2 && !miss_1) begin
          score1_d = score1_inc;
          dir_d    = 1'b1;
          timer_d  = '0;
          if (score1_inc == WIN) begin
            state_d  = OVER;
            winner_d = 2'b01;
          end else begin
            state_d = POINT;
          end
        end else if (miss_1 && miss_2) begin
          state_d = POINT;
          timer_d = '0;
        end
      end
      POINT: begin
        if (timer_q == PAUSE_LAST) begin
          state_d = SERVE;
          timer_d = '0;
        end else begin
          timer_d = timer_inc;
        end
      end
      OVER: begin
        if (b_rise) begin
          state_d  = SERVE;
          timer_d  = '0;
          score1_d = 3'd0;
          score2_d = 3'd0;
          winner_d = 2'b00;
          dir_d    = ~dir_q;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_1ms or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      score1_q <= 3'd0;
      score2_q <= 3'd0;
      dir_q    <= 1'b0;
      winner_q <= 2'b00;
      timer_q  <= '0;
      b_q      <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      dir_q    <= dir_d;
      winner_q <= winner_d;
      timer_q  <= timer_d;
      b_q      <= B;
      armed_q  <= armed_q | ~B;
    end
  end

  assign score_1     = score1_q;
  assign score_2     = score2_q;
  assign serve_dir   = dir_q;
  assign winner      = winner_q;
  assign state       = state_q;
  assign ball_en     = (state_q == RALLY);
  assign ball_center = (state_q == IDLE) || (state_q == SERVE);

endmodule
